// File: rtl/sha2_msg_schedule_if.sv
// Block-in / round-word-out bus of the SHA-2 message schedule.
// The slave modport is the scheduler. The master modport is the block source and word sink.
interface sha2_msg_schedule_if #(
  parameter int unsigned WORDSIZE = 32
);
  localparam int unsigned IDX_W = 7;

  logic [16*WORDSIZE-1:0] blk;
  logic                   blk_valid;
  logic                   blk_ready;
  logic [WORDSIZE-1:0]    w;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_last;
  logic                   w_valid;
  logic                   w_ready;

  modport master (
    output blk, blk_valid, w_ready,
    input  blk_ready, w, w_idx, w_last, w_valid
  );

  modport slave (
    input  blk, blk_valid, w_ready,
    output blk_ready, w, w_idx, w_last, w_valid
  );
endinterface

// File: rtl/sha2_msg_schedule.sv
// SHA-2 message schedule: one 16-word block in, ROUNDS schedule words out over a 16-word sliding window.
// Optional SHA2_SCHED_BACKTOBACK_EN: lets the next block be taken on the final-word handshake, so no bubble appears between blocks.
module sha2_msg_schedule #(
  parameter int unsigned WORDSIZE = 32,
  parameter int unsigned ROUNDS   = 64
) (
  input  logic               clk,
  input  logic               rst,
  sha2_msg_schedule_if.slave bus
);
  localparam int unsigned IDX_W = 7;
  localparam int unsigned WIN_N = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  // Rotate/shift amounts for sigma0/sigma1, chosen by word width
  localparam int unsigned S0_R1 = (WORDSIZE == 64) ? 1  : 7;
  localparam int unsigned S0_R2 = (WORDSIZE == 64) ? 8  : 18;
  localparam int unsigned S0_SH = (WORDSIZE == 64) ? 7  : 3;
  localparam int unsigned S1_R1 = (WORDSIZE == 64) ? 19 : 17;
  localparam int unsigned S1_R2 = (WORDSIZE == 64) ? 61 : 19;
  localparam int unsigned S1_SH = (WORDSIZE == 64) ? 6  : 10;

  typedef enum logic {IDLE, RUN} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    t_q, t_d;
  logic                last_q, last_d;
  logic                valid_q, valid_d;
  logic [WORDSIZE-1:0] win_q [WIN_N];
  logic [WORDSIZE-1:0] win_d [WIN_N];
  logic                blk_ready_c;
  logic                blk_acc_c;
  logic                w_hs_c;

  function automatic logic [WORDSIZE-1:0] rotr(input logic [WORDSIZE-1:0] x,
                                               input int unsigned n);
    return (x >> n) | (x << (WORDSIZE - n));
  endfunction

  function automatic logic [WORDSIZE-1:0] sig0(input logic [WORDSIZE-1:0] x);
    return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
  endfunction

  function automatic logic [WORDSIZE-1:0] sig1(input logic [WORDSIZE-1:0] x);
    return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
  endfunction

`ifdef SHA2_SCHED_BACKTOBACK_EN
  assign blk_ready_c = rst && ((state_q == IDLE) || (last_q && bus.w_ready));
`else
  assign blk_ready_c = rst && (state_q == IDLE);
`endif

  assign blk_acc_c = bus.blk_valid && blk_ready_c;
  assign w_hs_c    = (state_q == RUN) && bus.w_ready;

  // Next state: consume/shift on a word handshake, then let a block load override
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    last_d  = last_q;
    win_d   = win_q;

    unique case (state_q)
      IDLE: ;
      RUN: begin
        if (w_hs_c) begin
          for (int i = 0; i < WIN_N - 1; i++) win_d[i] = win_q[i+1];
          win_d[WIN_N-1] = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
          t_d    = t_q + IDX_W'(1);
          last_d = (t_d == LAST_IDX);
          if (t_q == LAST_IDX) begin
            state_d = IDLE;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (blk_acc_c) begin
      for (int i = 0; i < WIN_N; i++) win_d[i] = bus.blk[WORDSIZE*(WIN_N-1-i) +: WORDSIZE];
      t_d     = '0;
      last_d  = (LAST_IDX == '0);
      state_d = RUN;
    end

    valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < WIN_N; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      win_q   <= win_d;
    end
  end

  assign bus.blk_ready = blk_ready_c;
  assign bus.w         = win_q[0];
  assign bus.w_idx     = t_q;
  assign bus.w_last    = last_q;
  assign bus.w_valid   = valid_q;
endmodule

// File: tb/tb_sha2_msg_schedule.sv
// Bench for sha2_msg_schedule: a SHA-256 instance and a SHA-512 instance, each checked against a full-array schedule model.
// Expected block-to-block gap follows SHA2_SCHED_BACKTOBACK_EN.
module tb_sha2_msg_schedule;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32, rst64;
  sha2_msg_schedule_if #(.WORDSIZE(32)) bus32 ();
  sha2_msg_schedule_if #(.WORDSIZE(64)) bus64 ();

  sha2_msg_schedule #(.WORDSIZE(32), .ROUNDS(64)) u32 (.clk(clk), .rst(rst32), .bus(bus32.slave));
  sha2_msg_schedule #(.WORDSIZE(64), .ROUNDS(80)) u64 (.clk(clk), .rst(rst64), .bus(bus64.slave));

`ifdef SHA2_SCHED_BACKTOBACK_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 1;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [63:0] bw   [16];
  logic [63:0] expw [80];
  bit d64;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the textbook full-array schedule recurrence
  function automatic logic [63:0] msk(input int ws);
    return (ws == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int ws);
    return ((x >> n) | (x << (ws - n))) & msk(ws);
  endfunction
  function automatic logic [63:0] s0(input logic [63:0] x, input int ws);
    if (ws == 64) return rotr(x, 1, ws) ^ rotr(x, 8, ws) ^ (x >> 7);
    return rotr(x, 7, ws) ^ rotr(x, 18, ws) ^ (x >> 3);
  endfunction
  function automatic logic [63:0] s1(input logic [63:0] x, input int ws);
    if (ws == 64) return rotr(x, 19, ws) ^ rotr(x, 61, ws) ^ (x >> 6);
    return rotr(x, 17, ws) ^ rotr(x, 19, ws) ^ (x >> 10);
  endfunction
  task automatic build_ref(input int ws, input int rounds);
    for (int t = 0; t < 16; t++) expw[t] = bw[t] & msk(ws);
    for (int t = 16; t < rounds; t++)
      expw[t] = (s1(expw[t-2], ws) + expw[t-7] + s0(expw[t-15], ws) + expw[t-16]) & msk(ws);
  endtask

  function automatic logic valid_o();
    return d64 ? bus64.w_valid : bus32.w_valid;
  endfunction
  function automatic logic last_o();
    return d64 ? bus64.w_last : bus32.w_last;
  endfunction
  function automatic logic ready_o();
    return d64 ? bus64.blk_ready : bus32.blk_ready;
  endfunction
  function automatic logic [6:0] idx_o();
    return d64 ? bus64.w_idx : bus32.w_idx;
  endfunction
  function automatic logic [63:0] w_o();
    return d64 ? bus64.w : {32'h0, bus32.w};
  endfunction

  task automatic set_wr(input bit b);
    bus32.w_ready = b;
    bus64.w_ready = b;
  endtask
  task automatic set_bv(input bit b);
    if (d64) bus64.blk_valid = b;
    else     bus32.blk_valid = b;
  endtask
  task automatic set_blk();
    for (int i = 0; i < 16; i++) begin
      if (d64) bus64.blk[(16-i)*64-1 -: 64] = bw[i];
      else     bus32.blk[(16-i)*32-1 -: 32] = bw[i][31:0];
    end
  endtask
  task automatic rand_bw();
    for (int i = 0; i < 16; i++) bw[i] = {$urandom(), $urandom()};
  endtask

  // Present bw for one edge, then scramble the bus since the block may change after acceptance
  task automatic load_block();
    set_blk();
    set_bv(1'b1);
    @(negedge clk);
    set_bv(1'b0);
    if (d64) bus64.blk = ~bus64.blk;
    else     bus32.blk = ~bus32.blk;
  endtask

  // Take words [first, upto) from the stream, checking index, last flag and value at each handshake
  task automatic consume(input int rounds, input int first, input int upto, input bit rnd);
    int got = first;
    int cyc = 0;
    bit r;
    while (got < upto && cyc < 4000) begin
      r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      set_wr(r);
      if (valid_o() && r) begin
        check($sformatf("word%0d", got), {idx_o(), last_o(), w_o()},
              {7'(got), (got == rounds - 1), expw[got]});
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    check("stream_done", 128'(got), 128'(upto));
  endtask

  initial begin
    int g;
    rst32 = 1'b0; rst64 = 1'b0; d64 = 1'b0;
    bus32.blk = '0; bus64.blk = '0;
    bus32.blk_valid = 1'b0; bus64.blk_valid = 1'b0;
    set_wr(1'b0);
    repeat (2) @(negedge clk);

    // Reset state of both instances
    check("rst_valid32", bus32.w_valid, 1'b0);
    check("rst_ready32", bus32.blk_ready, 1'b0);
    check("rst_idx32",   bus32.w_idx, 7'd0);
    check("rst_w32",     bus32.w, 32'h0);
    check("rst_last32",  bus32.w_last, 1'b0);
    check("rst_valid64", bus64.w_valid, 1'b0);
    check("rst_ready64", bus64.blk_ready, 1'b0);
    rst32 = 1'b1; rst64 = 1'b1;
    #1;
    check("idle_ready32", bus32.blk_ready, 1'b1);
    check("idle_ready64", bus64.blk_ready, 1'b1);
    @(negedge clk);

    // "abc" block, SHA-256, full-rate consumer
    d64 = 1'b0;
    for (int i = 0; i < 16; i++) bw[i] = 64'h0;
    bw[0] = 64'h6162_6380; bw[15] = 64'h18;
    build_ref(32, 64);
    expw[0] = 64'h6162_6380; expw[15] = 64'h18;
    expw[16] = 64'h6162_6380; expw[17] = 64'h000F_0000;
    load_block();
    consume(64, 0, 64, 1'b0);
    check("end_valid_abc", valid_o(), 1'b0);
    @(negedge clk);

    // Random block: blk_valid pulse mid-block, then 5-cycle stall at w_idx 20
    rand_bw();
    build_ref(32, 64);
    load_block();
    consume(64, 0, 10, 1'b1);
    for (int i = 0; i < 16; i++) bus32.blk[(16-i)*32-1 -: 32] = $urandom();
    set_bv(1'b1);
    check("run_ready_low", ready_o(), 1'b0);
    consume(64, 10, 12, 1'b1);
    set_bv(1'b0);
    consume(64, 12, 20, 1'b0);
    set_wr(1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d", k), {valid_o(), idx_o(), last_o(), w_o()},
            {1'b1, 7'd20, 1'b0, expw[20]});
    end
    consume(64, 20, 64, 1'b1);
    check("end_valid_rand", valid_o(), 1'b0);
    @(negedge clk);

    // Reset for one cycle while w_idx is 30
    rand_bw();
    build_ref(32, 64);
    load_block();
    consume(64, 0, 30, 1'b1);
    rst32 = 1'b0;
    @(negedge clk);
    check("midrst_valid", valid_o(), 1'b0);
    check("midrst_ready", ready_o(), 1'b0);
    check("midrst_idx", idx_o(), 7'd0);
    rst32 = 1'b1;
    #1;
    check("midrst_release_ready", ready_o(), 1'b1);
    @(negedge clk);
    check("midrst_no_words", valid_o(), 1'b0);
    rand_bw();
    build_ref(32, 64);
    load_block();
    consume(64, 0, 64, 1'b1);

    // Back-to-back with blk_valid held high
    @(negedge clk);
    rand_bw();
    build_ref(32, 64);
    set_blk();
    set_bv(1'b1);
    @(negedge clk);
    consume(64, 0, 64, 1'b0);
    g = 0;
    while (!valid_o() && g < 4) begin
      g++;
      @(negedge clk);
    end
    check("b2b_gap", 128'(g), 128'(GAP));
    check("b2b_idx0", {valid_o(), idx_o()}, {1'b1, 7'd0});
    set_bv(1'b0);
    consume(64, 0, 64, 1'b1);
    check("b2b_end_valid", valid_o(), 1'b0);

    // "abc" block, SHA-512
    d64 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) bw[i] = 64'h0;
    bw[0] = 64'h6162_6380_0000_0000; bw[15] = 64'h18;
    build_ref(64, 80);
    expw[0] = 64'h6162_6380_0000_0000; expw[15] = 64'h18;
    expw[16] = 64'h6162_6380_0000_0000; expw[17] = 64'h0003_0000_0000_00C0;
    load_block();
    consume(80, 0, 80, 1'b1);
    check("end_valid_abc64", valid_o(), 1'b0);

    // Random block, SHA-512
    @(negedge clk);
    rand_bw();
    build_ref(64, 80);
    load_block();
    consume(80, 0, 80, 1'b1);
    check("end_valid_rand64", valid_o(), 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
